// File: rtl/multi_timer.sv
// multi_timer: memory-mapped multi-channel interval timer.
// NUM_CH channels share one prescaler that produces a one-cycle tick every
// CLK_RATE clocks. Each channel has CNT, LIM and CTL registers at
// BASE_ADDR + 16*c (+0, +4, +8; +12 reserved). STATUS sits at
// BASE_ADDR + 16*NUM_CH and holds the READY bits of all channels.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   abus     - byte address from processor (word aligned accesses)
//   dbus_in  - write data
//   wren     - 1 = write at abus, 0 = read
//   dbus_out - combinational read data (0 on writes, unmapped, reset)
//   irq      - registered OR over channels of READY & IE
module multi_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hF0000020,
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] CLK_RATE  = 32'd10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] abus,
    input  logic [31:0] dbus_in,
    input  logic        wren,
    output logic [31:0] dbus_out,
    output logic        irq
);

    localparam int              PW      = (CLK_RATE > 32'd1) ? $clog2(CLK_RATE) : 1;
    localparam logic [PW-1:0]   P_LAST  = PW'(CLK_RATE - 32'd1);
    localparam logic [31:0]     CH_SPAN = 32'(16 * NUM_CH);

    // CTL word layout: IE[8], ONESHOT[5], EN[4], OVERRUN[2], READY[0].
    function automatic logic [31:0] ctl_word(input logic ie, input logic os,
                                             input logic en, input logic ovr,
                                             input logic rdy);
        return {23'd0, ie, 2'b00, os, en, 1'b0, ovr, 1'b0, rdy};
    endfunction

    logic [PW-1:0]     pcnt_r;
    logic              tick_s;
    logic [31:0]       off_s;
    logic              hit_s;
    logic              stat_s;
    logic [2:0]        ch_s;
    logic [1:0]        reg_s;

    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic [CNT_W-1:0]  cnt_n [NUM_CH];
    logic [CNT_W-1:0]  lim_r [NUM_CH];
    logic [CNT_W-1:0]  lim_n [NUM_CH];
    logic [NUM_CH-1:0] en_r, en_n, os_r, os_n, ie_r, ie_n;
    logic [NUM_CH-1:0] rdy_r, rdy_n, ovr_r, ovr_n;
    logic [NUM_CH-1:0] sel_s, exp_s;
    logic [31:0]       rd_s;
    logic              irq_r;

    assign tick_s = (pcnt_r == P_LAST);

    // Address decode relative to channel 0; misaligned addresses are unmapped.
    assign off_s  = abus - BASE_ADDR;
    assign hit_s  = (off_s < CH_SPAN) && (off_s[1:0] == 2'b00);
    assign stat_s = (off_s == CH_SPAN);
    assign ch_s   = off_s[6:4];
    assign reg_s  = off_s[3:2];

    // Shared prescaler, free-running independent of channel enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_r <= '0;
        end else if (tick_s) begin
            pcnt_r <= '0;
        end else begin
            pcnt_r <= pcnt_r + PW'(1);
        end
    end

    // Per-channel write select and expire detection (from pre-write state).
    always_comb begin
        sel_s = '0;
        exp_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_s[c] = wren && hit_s && (ch_s == 3'(c));
            exp_s[c] = tick_s && en_r[c] && (lim_r[c] != '0) &&
                       (cnt_r[c] >= (lim_r[c] - CNT_W'(1)));
        end
    end

    // Next-state per channel. A CNT write beats the tick; an expire beats
    // a concurrent READY clear, and OVERRUN looks at READY before the write.
    always_comb begin
        cnt_n = cnt_r;
        lim_n = lim_r;
        en_n  = en_r;
        os_n  = os_r;
        ie_n  = ie_r;
        rdy_n = rdy_r;
        ovr_n = ovr_r;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_s[c] && (reg_s == 2'd0)) begin
                cnt_n[c] = dbus_in[CNT_W-1:0];
            end else if (exp_s[c]) begin
                cnt_n[c] = '0;
            end else if (tick_s && en_r[c]) begin
                cnt_n[c] = cnt_r[c] + CNT_W'(1);
            end else begin
                cnt_n[c] = cnt_r[c];
            end

            if (sel_s[c] && (reg_s == 2'd1)) begin
                lim_n[c] = dbus_in[CNT_W-1:0];
            end else begin
                lim_n[c] = lim_r[c];
            end

            if (sel_s[c] && (reg_s == 2'd2)) begin
                os_n[c] = dbus_in[5];
                ie_n[c] = dbus_in[8];
            end else begin
                os_n[c] = os_r[c];
                ie_n[c] = ie_r[c];
            end

            if (exp_s[c] && os_r[c]) begin
                en_n[c] = 1'b0;
            end else if (sel_s[c] && (reg_s == 2'd2)) begin
                en_n[c] = dbus_in[4];
            end else begin
                en_n[c] = en_r[c];
            end

            if (exp_s[c]) begin
                rdy_n[c] = 1'b1;
            end else if (sel_s[c] && (reg_s == 2'd2) && !dbus_in[0]) begin
                rdy_n[c] = 1'b0;
            end else begin
                rdy_n[c] = rdy_r[c];
            end

            if (exp_s[c] && rdy_r[c]) begin
                ovr_n[c] = 1'b1;
            end else if (sel_s[c] && (reg_s == 2'd2) && !dbus_in[2]) begin
                ovr_n[c] = 1'b0;
            end else begin
                ovr_n[c] = ovr_r[c];
            end
        end
    end

    // Channel state and interrupt registers; irq follows next-state flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_r[c] <= '0;
                lim_r[c] <= '0;
            end
            en_r  <= '0;
            os_r  <= '0;
            ie_r  <= '0;
            rdy_r <= '0;
            ovr_r <= '0;
            irq_r <= 1'b0;
        end else begin
            cnt_r <= cnt_n;
            lim_r <= lim_n;
            en_r  <= en_n;
            os_r  <= os_n;
            ie_r  <= ie_n;
            rdy_r <= rdy_n;
            ovr_r <= ovr_n;
            irq_r <= |(rdy_n & ie_n);
        end
    end

    // Read mux: OR of per-channel contributions keeps the decode latch-free.
    always_comb begin
        rd_s = 32'h0;
        if (rst && !wren && hit_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (reg_s)
                    2'd0:    rd_s = rd_s | ((ch_s == 3'(c)) ? 32'(cnt_r[c]) : 32'h0);
                    2'd1:    rd_s = rd_s | ((ch_s == 3'(c)) ? 32'(lim_r[c]) : 32'h0);
                    2'd2:    rd_s = rd_s | ((ch_s == 3'(c)) ?
                                ctl_word(ie_r[c], os_r[c], en_r[c], ovr_r[c], rdy_r[c]) : 32'h0);
                    default: rd_s = rd_s;
                endcase
            end
        end else if (rst && !wren && stat_s) begin
            rd_s = 32'(rdy_r);
        end else begin
            rd_s = 32'h0;
        end
    end

    assign dbus_out = rd_s;
    assign irq      = irq_r;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (CLK_RATE=4, NUM_CH=4). A second
// instance with CNT_W=8 shares the bus and covers truncation and wrap.
module tb_multi_timer;

    localparam logic [31:0] B  = 32'hF0000020;
    localparam logic [31:0] ST = B + 32'h40;

    logic        clk = 1'b0;
    logic        rst;
    logic        wren;
    logic [31:0] abus, dbus_in, dout32, dout8;
    logic        irq32, irq8;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_edge       = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    multi_timer #(.BASE_ADDR(B), .NUM_CH(4), .CNT_W(32), .CLK_RATE(32'd4)) dut (
        .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in), .wren(wren),
        .dbus_out(dout32), .irq(irq32));

    multi_timer #(.BASE_ADDR(B), .NUM_CH(4), .CNT_W(8), .CLK_RATE(32'd4)) dut8 (
        .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in), .wren(wren),
        .dbus_out(dout8), .irq(irq8));

    always #50 clk = ~clk;

    // Independent prescaler model: index of the next rising edge since reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) n_edge = 0;
        else      n_edge = n_edge + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag,
                      input bit use8 = 1'b0);
        abus = a;
        wren = 1'b0;
        sb_q.push_back('{tag, exp});
        #1;
        pop_chk(use8 ? dout8 : dout32);
    endtask

    task automatic irq_is(input logic exp, input string tag, input bit use8 = 1'b0);
        sb_q.push_back('{tag, 32'(exp)});
        #1;
        pop_chk(32'(use8 ? irq8 : irq32));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        abus    = a;
        dbus_in = d;
        wren    = 1'b1;
        #1;
        chk("wr_dbus_zero", dout32, 32'h0);
        @(negedge clk);
        wren    = 1'b0;
        dbus_in = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Park so that the next rising edge carries a tick.
    task automatic align_tick();
        repeat (4) if (n_edge % 4 != 3) @(negedge clk);
    endtask

    task automatic skip_ticks(input int n);
        repeat (n) begin
            align_tick();
            step(1);
        end
        align_tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] per_seq [3];
        per_seq[0] = 32'd1; per_seq[1] = 32'd2; per_seq[2] = 32'd0;
        rst = 1'b0; wren = 1'b0; abus = 32'h0; dbus_in = 32'h0;
        step(3);
        rst = 1'b1;

        // Reset aborting a running count.
        wr(B + 32'h4, 32'd100);
        wr(B + 32'h8, 32'h110);
        step(30);
        #2 rst = 1'b0;
        rd(B, 32'h0, "rst_dbus_low");
        irq_is(1'b0, "rst_irq_low");
        @(negedge clk);
        rst = 1'b1;
        rd(B,          32'h0, "rst_cnt0");
        rd(B + 32'h4,  32'h0, "rst_lim0");
        rd(B + 32'h8,  32'h0, "rst_ctl0");
        rd(ST,         32'h0, "rst_status");
        irq_is(1'b0, "rst_irq");

        // Readback and unmapped addresses.
        wr(B + 32'h14, 32'd5);
        rd(B + 32'h14, 32'd5, "lim1_rb");
        wr(B + 32'hC, 32'hDEAD_BEEF);
        rd(B + 32'hC, 32'h0, "reserved_rd");
        rd(32'hF000_0100, 32'h0, "unmapped_rd");

        // Periodic expire on ch0 with IE.
        wr(B + 32'h4, 32'd3);
        align_tick();
        wr(B + 32'h8, 32'h110);
        rd(B, 32'd0, "per_cnt_start");
        for (int i = 0; i < 3; i++) begin
            step(4);
            rd(B, per_seq[i], $sformatf("per_cnt_t%0d", i + 1));
            if (i == 1) rd(B + 32'h8, 32'h110, "per_ctl_pre");
        end
        rd(B + 32'h8, 32'h111, "per_ready");
        rd(ST, 32'h1, "per_status");
        step(1);
        irq_is(1'b1, "per_irq");
        wr(B + 32'h8, 32'h111);
        rd(B + 32'h8, 32'h111, "per_w1_keeps");
        wr(B + 32'h8, 32'h110);
        rd(B + 32'h8, 32'h110, "per_clear");
        step(1);
        irq_is(1'b0, "per_irq_clr");
        wr(B + 32'h8, 32'h0);

        // Overrun on ch1 (no IE).
        wr(B + 32'h14, 32'd2);
        align_tick();
        wr(B + 32'h18, 32'h010);
        step(8);
        rd(B + 32'h18, 32'h011, "ovr_first");
        step(8);
        rd(B + 32'h18, 32'h015, "ovr_set");
        rd(B + 32'h10, 32'h0, "ovr_cnt");
        step(8);
        rd(B + 32'h18, 32'h015, "ovr_stays");
        irq_is(1'b0, "ovr_no_irq");
        wr(B + 32'h18, 32'h0);
        rd(B + 32'h18, 32'h0, "ovr_clear");

        // One-shot on ch2.
        wr(B + 32'h24, 32'd4);
        align_tick();
        wr(B + 32'h28, 32'h030);
        step(12);
        rd(B + 32'h20, 32'd3, "os_cnt3");
        step(4);
        rd(B + 32'h28, 32'h021, "os_done");
        rd(B + 32'h20, 32'd0, "os_cnt0");
        step(40);
        rd(B + 32'h20, 32'd0, "os_hold");
        rd(B + 32'h28, 32'h021, "os_ctl_hold");
        rd(ST, 32'h4, "status_ch2");

        // CNT write coincident with tick on free-running ch3.
        wr(B + 32'h38, 32'h010);
        align_tick();
        wr(B + 32'h30, 32'd7);
        rd(B + 32'h30, 32'd7, "sim_cnt_wr");
        step(4);
        rd(B + 32'h30, 32'd8, "sim_cnt_inc");
        rd(B + 32'h38, 32'h010, "free_no_ready");

        // READY clear / disable coincident with expire on ch0 (LIM=3).
        wr(B, 32'd0);
        align_tick();
        wr(B + 32'h8, 32'h010);
        skip_ticks(2);
        wr(B + 32'h8, 32'h010);
        rd(B + 32'h8, 32'h011, "sim_clr_vs_exp");
        rd(B, 32'd0, "sim_exp_cnt");
        skip_ticks(2);
        wr(B + 32'h8, 32'h010);
        rd(B + 32'h8, 32'h015, "sim_clr_vs_exp_ovr");
        skip_ticks(2);
        wr(B + 32'h8, 32'h000);
        rd(B + 32'h8, 32'h005, "sim_dis_vs_exp");
        step(8);
        rd(B, 32'd0, "sim_dis_hold");

        // 8-bit counter wrap and truncation on dut8 ch3.
        align_tick();
        wr(B + 32'h30, 32'hFE);
        rd(B + 32'h30, 32'hFE, "wrap_fe", 1'b1);
        align_tick();
        step(1);
        rd(B + 32'h30, 32'hFF, "wrap_ff", 1'b1);
        align_tick();
        step(1);
        rd(B + 32'h30, 32'h00, "wrap_00", 1'b1);
        rd(B + 32'h38, 32'h010, "wrap_no_ready", 1'b1);
        wr(B + 32'h38, 32'h0);
        wr(B + 32'h30, 32'h1234);
        rd(B + 32'h30, 32'h34, "trunc8", 1'b1);
        rd(B + 32'h30, 32'h1234, "full32");
        irq_is(1'b0, "irq8_idle", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
